carrier_mod_ctrl: RTL and testbench

CARRIER_MOD_CTRL -- requirements
Module: carrier_mod_ctrl

---
 rtl/carrier_mod_ctrl_pkg.sv | 45 ++++
 rtl/carrier_mod_ctrl_sym_fifo.sv | 76 +++++++
 rtl/carrier_mod_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_carrier_mod_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carrier_mod_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// carrier_mod_ctrl_pkg
// Shared definitions for the QPSK carrier modulation controller:
//   - carrier table length and quarter-period phase step
//   - controller state enumeration
//   - Gray-coded symbol to phase-offset mapping
//   - modulo-CARRIER_LEN addition used to form the table index
// ---------------------------------------------------------------------------
package carrier_mod_ctrl_pkg;

    localparam int unsigned CARRIER_LEN = 200;
    localparam int unsigned QUARTER     = 50;
    localparam logic [7:0]  LAST_BASE   = 8'(CARRIER_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Gray mapping: adjacent phases differ by one bit.
    function automatic logic [7:0] sym_to_offset(input logic [1:0] sym);
        logic [7:0] off;
        case (sym)
            2'b00:   off = 8'd0;
            2'b01:   off = 8'(QUARTER);
            2'b11:   off = 8'(2 * QUARTER);
            default: off = 8'(3 * QUARTER);
        endcase
        return off;
    endfunction

    // Both operands are below CARRIER_LEN, so a single conditional
    // subtraction is enough to fold the sum back into 0..CARRIER_LEN-1.
    function automatic logic [7:0] carrier_wrap_add(input logic [7:0] base,
                                                    input logic [7:0] offset);
        logic [8:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= 9'(CARRIER_LEN)) begin
            sum = sum - 9'(CARRIER_LEN);
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/carrier_mod_ctrl_sym_fifo.sv
// ---------------------------------------------------------------------------
// sym_fifo
// Synchronous FIFO holding queued QPSK symbols, with an occupancy output.
// Head entry is presented combinationally on o_rdata (show-ahead).
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, empties the FIFO
//   i_push   in   write i_wdata this cycle (ignored when full)
//   i_wdata  in   symbol to write
//   i_pop    in   discard head entry this cycle (ignored when empty)
//   o_rdata  out  current head entry
//   o_full   out  occupancy == DEPTH
//   o_empty  out  occupancy == 0
//   o_level  out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sym_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/carrier_mod_ctrl.sv
// ---------------------------------------------------------------------------
// carrier_mod_ctrl
// QPSK carrier modulation controller. Buffers 2-bit symbols, then walks a
// 200-entry sine/cosine table index, shifting its phase by the Gray-mapped
// offset of the current symbol. Each symbol lasts SYM_PERIODS carrier periods.
//
// Handshake: a symbol is taken on every rising edge where sym_valid and
// sym_ready are both high; sym_ready is high whenever the buffer is not full
// and does not depend on sym_valid.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   sym_data    in   QPSK symbol to enqueue
//   sym_valid   in   sym_data valid this cycle
//   sym_ready   out  buffer not full
//   start       in   one-cycle request to begin transmitting
//   stop        in   one-cycle request to end at the next symbol boundary
//   lut_addr    out  carrier table index 0..199
//   carrier_en  out  lut_addr valid, carrier driven
//   sym_strobe  out  pulse on the first clock of each symbol
//   busy        out  controller not idle
//   underrun    out  sticky: buffer ran dry with no stop pending
//   fifo_level  out  buffer occupancy
//   dbg_state   out  controller state
// ---------------------------------------------------------------------------
module carrier_mod_ctrl
    import carrier_mod_ctrl_pkg::*;
#(
    parameter  int SYM_PERIODS = 4,
    parameter  int FIFO_DEPTH  = 4,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sym_data,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       lut_addr,
    output logic             carrier_en,
    output logic             sym_strobe,
    output logic             busy,
    output logic             underrun,
    output logic [LVL_W-1:0] fifo_level,
    output state_t           dbg_state
);

    localparam logic [7:0] LAST_PERIOD = 8'(SYM_PERIODS - 1);

    state_t     r_state;
    logic [7:0] r_base;
    logic [7:0] r_period_cnt;
    logic [7:0] r_offset;
    logic [7:0] r_lut_addr;
    logic       r_sym_strobe;
    logic       r_underrun;

    state_t     w_next_state;
    logic [7:0] w_next_base;
    logic [7:0] w_next_period;
    logic [7:0] w_next_offset;
    logic [7:0] w_next_lut;
    logic       w_next_strobe;
    logic       w_next_underrun;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [1:0] w_head;
    logic       w_base_wrap;
    logic       w_boundary;

    sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_sym_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (sym_valid),
        .i_wdata (sym_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign sym_ready   = !w_full;
    assign w_base_wrap = (r_base == LAST_BASE);
    assign w_boundary  = w_base_wrap && (r_period_cnt == LAST_PERIOD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_period_cnt <= '0;
            r_offset     <= '0;
            r_lut_addr   <= '0;
            r_sym_strobe <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_base       <= w_next_base;
            r_period_cnt <= w_next_period;
            r_offset     <= w_next_offset;
            r_lut_addr   <= w_next_lut;
            r_sym_strobe <= w_next_strobe;
            r_underrun   <= w_next_underrun;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_base     = r_base;
        w_next_period   = r_period_cnt;
        w_next_offset   = r_offset;
        w_next_strobe   = 1'b0;
        w_next_underrun = r_underrun;
        w_pop           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_base   = '0;
                w_next_period = '0;
                // start wins over a simultaneous stop.
                if (start) begin
                    if (!w_empty) begin
                        w_next_state    = ST_RUN;
                        w_pop           = 1'b1;
                        w_next_offset   = sym_to_offset(w_head);
                        w_next_underrun = 1'b0;
                        w_next_strobe   = 1'b1;
                    end else begin
                        w_next_underrun = 1'b1;
                    end
                end
            end

            ST_RUN, ST_DRAIN: begin
                w_next_base   = w_base_wrap ? 8'd0 : r_base + 8'd1;
                w_next_period = w_base_wrap ? r_period_cnt + 8'd1 : r_period_cnt;
                if (w_boundary) begin
                    w_next_period = '0;
                    // A stop arriving on the boundary cycle itself ends
                    // transmission here, exactly as DRAIN would.
                    if (r_state == ST_DRAIN || stop) begin
                        w_next_state = ST_IDLE;
                    end else if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_next_offset = sym_to_offset(w_head);
                        w_next_strobe = 1'b1;
                    end else begin
                        w_next_state    = ST_IDLE;
                        w_next_underrun = 1'b1;
                    end
                end else if (r_state == ST_RUN && stop) begin
                    w_next_state = ST_DRAIN;
                end
            end

            default: begin
                w_next_state  = ST_IDLE;
                w_next_base   = '0;
                w_next_period = '0;
            end
        endcase

        // Index is formed from the next base/offset so it lands on the same
        // edge as the counter it is derived from.
        w_next_lut = (w_next_state == ST_IDLE) ? 8'd0
                                               : carrier_wrap_add(w_next_base, w_next_offset);
    end

    assign lut_addr   = r_lut_addr;
    assign carrier_en = (r_state != ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign sym_strobe = r_sym_strobe;
    assign underrun   = r_underrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_carrier_mod_ctrl.sv
// ---------------------------------------------------------------------------
// tb_carrier_mod_ctrl
// Directed bench for carrier_mod_ctrl. Two instances share all inputs:
//   dut_a : default parameters (SYM_PERIODS=4, FIFO_DEPTH=4)
//   dut_b : SYM_PERIODS=1 for the full-sequence and boundary scenarios
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_carrier_mod_ctrl;
    import carrier_mod_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sym_data = 2'b00;
    logic       sym_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;

    logic       a_sym_ready, a_carrier_en, a_sym_strobe, a_busy, a_underrun;
    logic [7:0] a_lut_addr;
    logic [2:0] a_fifo_level;
    state_t     a_dbg_state;

    logic       b_sym_ready, b_carrier_en, b_sym_strobe, b_busy, b_underrun;
    logic [7:0] b_lut_addr;
    logic [2:0] b_fifo_level;
    state_t     b_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    carrier_mod_ctrl #(.SYM_PERIODS(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .sym_data(sym_data), .sym_valid(sym_valid),
        .sym_ready(a_sym_ready), .start(start), .stop(stop),
        .lut_addr(a_lut_addr), .carrier_en(a_carrier_en), .sym_strobe(a_sym_strobe),
        .busy(a_busy), .underrun(a_underrun), .fifo_level(a_fifo_level),
        .dbg_state(a_dbg_state)
    );

    carrier_mod_ctrl #(.SYM_PERIODS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .sym_data(sym_data), .sym_valid(sym_valid),
        .sym_ready(b_sym_ready), .start(start), .stop(stop),
        .lut_addr(b_lut_addr), .carrier_en(b_carrier_en), .sym_strobe(b_sym_strobe),
        .busy(b_busy), .underrun(b_underrun), .fifo_level(b_fifo_level),
        .dbg_state(b_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; sym_valid = 1'b0; start = 1'b0; stop = 1'b0; sym_data = 2'b00;
        tick; tick;
        rst = 1'b1;
        tick;
    endtask

    // ---------------- drivers ----------------
    task automatic push(input logic [1:0] s);
        sym_data = s; sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0;
        tick; tick;
        n_checks++; if (a_lut_addr !== 8'd0) $display("FAIL rst_lut: got %0d expected 0", a_lut_addr); else n_pass++;
        n_checks++; if (a_carrier_en !== 1'b0) $display("FAIL rst_carrier_en: got %b expected 0", a_carrier_en); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", a_busy); else n_pass++;
        n_checks++; if (a_sym_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", a_sym_ready); else n_pass++;
        n_checks++; if (a_fifo_level !== 3'd0) $display("FAIL rst_level: got %0d expected 0", a_fifo_level); else n_pass++;
        n_checks++; if (a_underrun !== 1'b0) $display("FAIL rst_underrun: got %b expected 0", a_underrun); else n_pass++;
        n_checks++; if (a_sym_strobe !== 1'b0) $display("FAIL rst_strobe: got %b expected 0", a_sym_strobe); else n_pass++;
        n_checks++; if (a_dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d expected 0", a_dbg_state); else n_pass++;
        rst = 1'b1;
        tick;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL rst_release_busy: got %b expected 0", b_busy); else n_pass++;
    endtask

    // Four symbols, one carrier period each, on dut_b.
    task automatic test_sequence;
        int offs [4];
        int exp_lut;
        offs = '{0, 50, 100, 150};
        do_reset;
        push(2'b00); push(2'b01); push(2'b11); push(2'b10);
        pulse_start;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 200; i++) begin
                exp_lut = (i + offs[k]) % 200;
                n_checks++;
                if (b_lut_addr !== 8'(exp_lut))
                    $display("FAIL seq_lut sym%0d idx%0d: got %0d expected %0d", k, i, b_lut_addr, exp_lut);
                else n_pass++;
                n_checks++;
                if (b_sym_strobe !== (i == 0))
                    $display("FAIL seq_strobe sym%0d idx%0d: got %b expected %b", k, i, b_sym_strobe, (i == 0));
                else n_pass++;
                if (i == 100) begin
                    n_checks++;
                    if (b_carrier_en !== 1'b1) $display("FAIL seq_carrier_en sym%0d: got %b expected 1", k, b_carrier_en); else n_pass++;
                end
                tick;
            end
        end
        n_checks++; if (b_busy !== 1'b0) $display("FAIL seq_end_busy: got %b expected 0", b_busy); else n_pass++;
        n_checks++; if (b_underrun !== 1'b1) $display("FAIL seq_end_underrun: got %b expected 1", b_underrun); else n_pass++;
        n_checks++; if (b_lut_addr !== 8'd0) $display("FAIL seq_end_lut: got %0d expected 0", b_lut_addr); else n_pass++;
        n_checks++; if (b_carrier_en !== 1'b0) $display("FAIL seq_end_carrier_en: got %b expected 0", b_carrier_en); else n_pass++;
    endtask

    // Stop 10 cycles into an 800-cycle symbol on dut_a.
    task automatic test_stop_drain;
        int cnt;
        int strobes;
        do_reset;
        push(2'b00); push(2'b01);
        pulse_start;
        n_checks++; if (a_fifo_level !== 3'd1) $display("FAIL drain_level_start: got %0d expected 1", a_fifo_level); else n_pass++;
        repeat (10) tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        n_checks++; if (a_dbg_state !== ST_DRAIN) $display("FAIL drain_state: got %0d expected 2", a_dbg_state); else n_pass++;
        n_checks++; if (a_lut_addr !== 8'd11) $display("FAIL drain_lut: got %0d expected 11", a_lut_addr); else n_pass++;
        cnt = 0;
        strobes = 0;
        while (a_busy && cnt < 2000) begin
            tick;
            cnt++;
            if (a_sym_strobe) strobes++;
        end
        n_checks++; if (cnt !== 789) $display("FAIL drain_cycles: got %0d expected 789", cnt); else n_pass++;
        n_checks++; if (strobes !== 0) $display("FAIL drain_strobes: got %0d expected 0", strobes); else n_pass++;
        n_checks++; if (a_fifo_level !== 3'd1) $display("FAIL drain_level_end: got %0d expected 1", a_fifo_level); else n_pass++;
        n_checks++; if (a_underrun !== 1'b0) $display("FAIL drain_underrun: got %b expected 0", a_underrun); else n_pass++;
        n_checks++; if (a_carrier_en !== 1'b0) $display("FAIL drain_carrier_en: got %b expected 0", a_carrier_en); else n_pass++;
    endtask

    // Five back-to-back pushes into a 4-deep buffer on dut_a.
    task automatic test_back_to_back;
        logic [1:0] syms [5];
        int exp_lvl;
        syms = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        do_reset;
        sym_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sym_data = syms[i];
            tick;
            exp_lvl = (i + 1 > 4) ? 4 : i + 1;
            n_checks++;
            if (a_fifo_level !== 3'(exp_lvl)) $display("FAIL b2b_level push%0d: got %0d expected %0d", i, a_fifo_level, exp_lvl);
            else n_pass++;
        end
        n_checks++; if (a_sym_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b expected 0", a_sym_ready); else n_pass++;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++; if (a_fifo_level !== 3'd3) $display("FAIL b2b_level_pop: got %0d expected 3", a_fifo_level); else n_pass++;
        n_checks++; if (a_sym_ready !== 1'b1) $display("FAIL b2b_ready_pop: got %b expected 1", a_sym_ready); else n_pass++;
        n_checks++; if (a_lut_addr !== 8'd50) $display("FAIL b2b_first_lut: got %0d expected 50", a_lut_addr); else n_pass++;
        tick;
        sym_valid = 1'b0;
        n_checks++; if (a_fifo_level !== 3'd4) $display("FAIL b2b_level_held: got %0d expected 4", a_fifo_level); else n_pass++;
        n_checks++; if (a_lut_addr !== 8'd51) $display("FAIL b2b_lut_next: got %0d expected 51", a_lut_addr); else n_pass++;
    endtask

    // start on empty buffer, then a valid start (with stop in the same cycle).
    task automatic test_underrun_start;
        do_reset;
        pulse_start;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL ur_busy: got %b expected 0", a_busy); else n_pass++;
        n_checks++; if (a_underrun !== 1'b1) $display("FAIL ur_set: got %b expected 1", a_underrun); else n_pass++;
        push(2'b11);
        n_checks++; if (a_underrun !== 1'b1) $display("FAIL ur_sticky: got %b expected 1", a_underrun); else n_pass++;
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        n_checks++; if (a_dbg_state !== ST_RUN) $display("FAIL ur_state_run: got %0d expected 1", a_dbg_state); else n_pass++;
        n_checks++; if (a_underrun !== 1'b0) $display("FAIL ur_clear: got %b expected 0", a_underrun); else n_pass++;
        n_checks++; if (a_lut_addr !== 8'd100) $display("FAIL ur_lut: got %0d expected 100", a_lut_addr); else n_pass++;
        n_checks++; if (a_sym_strobe !== 1'b1) $display("FAIL ur_strobe: got %b expected 1", a_sym_strobe); else n_pass++;
        tick;
        n_checks++; if (a_sym_strobe !== 1'b0) $display("FAIL ur_strobe_pulse: got %b expected 0", a_sym_strobe); else n_pass++;
        n_checks++; if (a_lut_addr !== 8'd101) $display("FAIL ur_lut_next: got %0d expected 101", a_lut_addr); else n_pass++;
    endtask

    // Asynchronous reset at base=123 with 3 symbols buffered.
    task automatic test_reset_mid;
        do_reset;
        push(2'b00); push(2'b01); push(2'b11); push(2'b10);
        pulse_start;
        repeat (123) tick;
        n_checks++; if (a_lut_addr !== 8'd123) $display("FAIL mid_lut_pre: got %0d expected 123", a_lut_addr); else n_pass++;
        n_checks++; if (a_fifo_level !== 3'd3) $display("FAIL mid_level_pre: got %0d expected 3", a_fifo_level); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (a_lut_addr !== 8'd0) $display("FAIL mid_lut: got %0d expected 0", a_lut_addr); else n_pass++;
        n_checks++; if (a_carrier_en !== 1'b0) $display("FAIL mid_carrier_en: got %b expected 0", a_carrier_en); else n_pass++;
        n_checks++; if (a_fifo_level !== 3'd0) $display("FAIL mid_level: got %0d expected 0", a_fifo_level); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", a_busy); else n_pass++;
        n_checks++; if (a_sym_ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", a_sym_ready); else n_pass++;
        tick; tick;
        rst = 1'b1;
        tick;
        push(2'b10);
        pulse_start;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL mid_restart_busy: got %b expected 1", a_busy); else n_pass++;
        n_checks++; if (a_lut_addr !== 8'd150) $display("FAIL mid_restart_lut: got %0d expected 150", a_lut_addr); else n_pass++;
    endtask

    // Push on the boundary-pop cycle with two symbols queued, on dut_b.
    task automatic test_boundary_push;
        do_reset;
        push(2'b01); push(2'b11); push(2'b10);
        pulse_start;
        n_checks++; if (b_fifo_level !== 3'd2) $display("FAIL bp_level_start: got %0d expected 2", b_fifo_level); else n_pass++;
        n_checks++; if (b_lut_addr !== 8'd50) $display("FAIL bp_lut_start: got %0d expected 50", b_lut_addr); else n_pass++;
        repeat (199) tick;
        n_checks++; if (b_lut_addr !== 8'd49) $display("FAIL bp_lut_last: got %0d expected 49", b_lut_addr); else n_pass++;
        sym_data = 2'b00; sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        n_checks++; if (b_fifo_level !== 3'd2) $display("FAIL bp_level_same: got %0d expected 2", b_fifo_level); else n_pass++;
        n_checks++; if (b_sym_strobe !== 1'b1) $display("FAIL bp_strobe1: got %b expected 1", b_sym_strobe); else n_pass++;
        n_checks++; if (b_lut_addr !== 8'd100) $display("FAIL bp_lut_sym1: got %0d expected 100", b_lut_addr); else n_pass++;
        repeat (200) tick;
        n_checks++; if (b_lut_addr !== 8'd150) $display("FAIL bp_lut_sym2: got %0d expected 150", b_lut_addr); else n_pass++;
        n_checks++; if (b_fifo_level !== 3'd1) $display("FAIL bp_level_sym2: got %0d expected 1", b_fifo_level); else n_pass++;
        repeat (200) tick;
        n_checks++; if (b_lut_addr !== 8'd0) $display("FAIL bp_lut_sym3: got %0d expected 0", b_lut_addr); else n_pass++;
        n_checks++; if (b_sym_strobe !== 1'b1) $display("FAIL bp_strobe3: got %b expected 1", b_sym_strobe); else n_pass++;
        n_checks++; if (b_fifo_level !== 3'd0) $display("FAIL bp_level_sym3: got %0d expected 0", b_fifo_level); else n_pass++;
        repeat (200) tick;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL bp_end_busy: got %b expected 0", b_busy); else n_pass++;
        n_checks++; if (b_underrun !== 1'b1) $display("FAIL bp_end_underrun: got %b expected 1", b_underrun); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_sequence;
        test_stop_drain;
        test_back_to_back;
        test_underrun_start;
        test_reset_mid;
        test_boundary_push;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
